// File: rtl/alu_flag_unit_if.sv
// Branch-condition bus: flag write port, request/response handshakes and status.
// Master side drives flags and requests; slave side is the alu_flag_unit.
interface alu_flag_unit_if;
  localparam int unsigned COND_W = 3;
  localparam int unsigned FLAG_W = 3;

  logic              flag_we;
  logic              zin;
  logic              nin;
  logic              vin;
  logic              br_valid;
  logic [COND_W-1:0] br_cond;
  logic              br_ready;
  logic              tk_valid;
  logic              tk_ready;
  logic              taken;
  logic [FLAG_W-1:0] flags;
  logic              stall;

  modport master (
    output flag_we, zin, nin, vin, br_valid, br_cond, tk_ready,
    input  br_ready, tk_valid, taken, flags, stall
  );

  modport slave (
    input  flag_we, zin, nin, vin, br_valid, br_cond, tk_ready,
    output br_ready, tk_valid, taken, flags, stall
  );
endinterface

// File: rtl/alu_flag_unit.sv
// ALU flag register plus branch-condition evaluator with a valid/ready
// request side and a valid/ready result side.
// Build option FLAG_FWD_EN: a request accepted in the same cycle as a flag
// write evaluates against the incoming flags directly instead of waiting a
// cycle for the flag register to update.
module alu_flag_unit (
  input logic            clk,
  input logic            rst_n,
  alu_flag_unit_if.slave bus
);
  localparam int unsigned COND_W = 3;
  localparam int unsigned FLAG_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [FLAG_W-1:0] flags_q;
  logic [FLAG_W-1:0] flags_d;
  logic [FLAG_W-1:0] flags_in;
  logic              taken_q;
  logic              taken_d;
  logic              tk_valid_q;
  logic              accept;
  logic              hazard;
  logic              br_ready_int;
`ifndef FLAG_FWD_EN
  logic [COND_W-1:0] cond_q;
  logic [COND_W-1:0] cond_d;
  logic              stall_q;
`endif

  // Condition decode against a {Z,N,V} flag vector.
  function automatic logic cond_eval(input logic [COND_W-1:0] cond,
                                     input logic [FLAG_W-1:0] f);
    logic z;
    logic n;
    logic v;
    logic r;
    z = f[2];
    n = f[1];
    v = f[0];
    case (cond)
      3'b000:  r = z;
      3'b001:  r = ~z;
      3'b010:  r = n ^ v;
      3'b011:  r = ~(n ^ v);
      3'b100:  r = v;
      3'b101:  r = ~v;
      3'b110:  r = n;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  // Request handshake: free when idle, or when the held result leaves this cycle.
  assign br_ready_int = (state_q == ST_IDLE) ||
                        ((state_q == ST_HOLD) && bus.tk_ready);
  assign accept       = bus.br_valid && br_ready_int;
  assign hazard       = accept && bus.flag_we;
  assign flags_in     = {bus.zin, bus.nin, bus.vin};

  // Next-state, flag write and result evaluation.
  always_comb begin
    state_d = state_q;
    flags_d = flags_q;
    taken_d = taken_q;
`ifndef FLAG_FWD_EN
    cond_d  = cond_q;
`endif
    if (bus.flag_we) begin
      flags_d = flags_in;
    end
    case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (accept) begin
          if (hazard) begin
`ifdef FLAG_FWD_EN
            taken_d = cond_eval(bus.br_cond, flags_in);
            state_d = ST_HOLD;
`else
            cond_d  = bus.br_cond;
            state_d = ST_WAIT;
`endif
          end else begin
            taken_d = cond_eval(bus.br_cond, flags_q);
            state_d = ST_HOLD;
          end
        end else if ((state_q == ST_HOLD) && bus.tk_ready) begin
          state_d = ST_IDLE;
        end
      end
`ifndef FLAG_FWD_EN
      ST_WAIT: begin
        // Flag register now holds the value written alongside the request.
        taken_d = cond_eval(cond_q, flags_q);
        state_d = ST_HOLD;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      flags_q    <= '0;
      taken_q    <= 1'b0;
      tk_valid_q <= 1'b0;
`ifndef FLAG_FWD_EN
      cond_q     <= '0;
      stall_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      flags_q    <= flags_d;
      taken_q    <= taken_d;
      tk_valid_q <= (state_d == ST_HOLD);
`ifndef FLAG_FWD_EN
      cond_q     <= cond_d;
      stall_q    <= (state_d == ST_WAIT);
`endif
    end
  end

  assign bus.br_ready = br_ready_int;
  assign bus.tk_valid = tk_valid_q;
  assign bus.taken    = taken_q;
  assign bus.flags    = flags_q;
`ifdef FLAG_FWD_EN
  assign bus.stall    = 1'b0;
`else
  assign bus.stall    = stall_q;
`endif

endmodule

// File: tb/tb_alu_flag_unit.sv
// Self-checking bench for alu_flag_unit: directed scenarios followed by random
// traffic, all compared against a result-slot reference model.
module tb_alu_flag_unit;
  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  alu_flag_unit_if bus_if ();

  alu_flag_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  // Reference model: one result slot, one pending (hazard) request, flags.
  bit         m_fwd;
  logic [2:0] m_flags;
  bit         m_slot_v;
  bit         m_slot_val;
  bit         m_pend_v;
  logic [2:0] m_pend_cond;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Branch condition truth from the condition table.
  function automatic bit cond_true(input logic [2:0] cond, input logic [2:0] f);
    int z = int'(f[2]);
    int n = int'(f[1]);
    int v = int'(f[0]);
    case (cond)
      3'd0:    return z == 1;
      3'd1:    return z == 0;
      3'd2:    return n != v;
      3'd3:    return n == v;
      3'd4:    return v == 1;
      3'd5:    return v == 0;
      3'd6:    return n == 1;
      default: return 1'b1;
    endcase
  endfunction

  // One clock cycle: drive inputs, check ready, update model, check outputs.
  task automatic cycle(input bit r, input bit fw, input bit z, input bit n, input bit v,
                       input bit bv, input logic [2:0] cond, input bit tr);
    bit         ready_exp;
    bit         acc;
    logic [2:0] nf;
    @(negedge clk);
    rst_n           = r;
    bus_if.flag_we  = fw;
    bus_if.zin      = z;
    bus_if.nin      = n;
    bus_if.vin      = v;
    bus_if.br_valid = bv;
    bus_if.br_cond  = cond;
    bus_if.tk_ready = tr;
    #1;
    ready_exp = !m_pend_v && (!m_slot_v || tr);
    check("br_ready", 32'(bus_if.br_ready), 32'(ready_exp));
    acc = bv && ready_exp;
    @(posedge clk);
    if (!r) begin
      m_flags  = 3'b000;
      m_slot_v = 1'b0;
      m_pend_v = 1'b0;
    end else begin
      nf = fw ? {z, n, v} : m_flags;
      if (m_pend_v) begin
        m_slot_v   = 1'b1;
        m_slot_val = cond_true(m_pend_cond, m_flags);
        m_pend_v   = 1'b0;
      end else if (acc) begin
        if (fw && !m_fwd) begin
          m_pend_v    = 1'b1;
          m_pend_cond = cond;
          m_slot_v    = 1'b0;
        end else begin
          m_slot_v   = 1'b1;
          m_slot_val = cond_true(cond, nf);
        end
      end else if (m_slot_v && tr) begin
        m_slot_v = 1'b0;
      end
      m_flags = nf;
    end
    #1;
    check("tk_valid", 32'(bus_if.tk_valid), 32'(m_slot_v));
    check("stall", 32'(bus_if.stall), 32'(m_pend_v));
    check("flags", 32'(bus_if.flags), 32'(m_flags));
    if (!r) check("taken_rst", 32'(bus_if.taken), 32'd0);
    else if (m_slot_v) check("taken", 32'(bus_if.taken), 32'(m_slot_val));
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(1, 0, 0, 0, 0, 0, 3'd0, 1);
  endtask

  initial begin
`ifdef FLAG_FWD_EN
    m_fwd = 1'b1;
`else
    m_fwd = 1'b0;
`endif
    m_flags = 3'b000; m_slot_v = 1'b0; m_slot_val = 1'b0;
    m_pend_v = 1'b0; m_pend_cond = 3'd0;
    rst_n = 1'b0;
    bus_if.flag_we = 1'b0; bus_if.zin = 1'b0; bus_if.nin = 1'b0; bus_if.vin = 1'b0;
    bus_if.br_valid = 1'b0; bus_if.br_cond = 3'd0; bus_if.tk_ready = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state, with flag write and request presented under reset.
    cycle(0, 1, 1, 1, 1, 1, 3'd7, 1);
    idle(1);

    // Z=1 then EQ / NE back to back.
    cycle(1, 1, 1, 0, 0, 0, 3'd0, 1);
    cycle(1, 0, 0, 0, 0, 1, 3'd0, 1);
    cycle(1, 0, 0, 0, 0, 1, 3'd1, 1);
    idle(1);

    // LT / GE with N,V combinations.
    cycle(1, 1, 0, 1, 1, 0, 3'd0, 1);
    cycle(1, 0, 0, 0, 0, 1, 3'd2, 1);
    cycle(1, 1, 0, 1, 0, 0, 3'd0, 1);
    cycle(1, 0, 0, 0, 0, 1, 3'd2, 1);
    cycle(1, 0, 0, 0, 0, 1, 3'd3, 1);
    idle(1);

    // AL held under backpressure; flag writes and requests during the hold.
    cycle(1, 0, 0, 0, 0, 1, 3'd7, 0);
    cycle(1, 1, 1, 1, 1, 1, 3'd1, 0);
    cycle(1, 1, 0, 0, 1, 1, 3'd0, 0);
    cycle(1, 1, 1, 0, 0, 1, 3'd5, 0);
    cycle(1, 0, 0, 0, 0, 0, 3'd0, 1);
    idle(1);

    // Hazard: flag write of Z=1 together with an EQ request.
    cycle(1, 1, 0, 0, 0, 0, 3'd0, 1);
    cycle(1, 1, 1, 0, 0, 1, 3'd0, 1);
    idle(3);

    // Reset while holding a result.
    cycle(1, 1, 1, 1, 0, 1, 3'd6, 0);
    cycle(0, 0, 0, 0, 0, 0, 3'd0, 0);
    idle(2);
    // Reset right after a hazard accept.
    cycle(1, 1, 0, 1, 0, 1, 3'd2, 1);
    cycle(0, 0, 0, 0, 0, 0, 3'd0, 1);
    idle(2);

    // VS / VC back to back with V=1.
    cycle(1, 1, 0, 0, 1, 0, 3'd0, 1);
    cycle(1, 0, 0, 0, 0, 1, 3'd4, 1);
    cycle(1, 0, 0, 0, 0, 1, 3'd5, 1);
    idle(1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 2) == 0),
            1'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 3) != 0), 3'($urandom),
            ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_flag_unit.md
ALU_FLAG_UNIT -- requirements
Module: alu_flag_unit

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-003 SHALL have port flag_we, input, 1: capture zin/nin/vin into the flag register this edge.
REQ-004 SHALL have ports zin, nin, vin, input, 1 each: zero, negative and overflow flags from the ALU.
REQ-005 SHALL have port br_valid, input, 1: branch-condition evaluation request.
REQ-006 SHALL have port br_cond, input, 3: condition code, sampled when br_valid and br_ready are both 1.
REQ-007 SHALL have port br_ready, output, 1: unit can accept a request this cycle.
REQ-008 SHALL have port tk_valid, output, 1: taken result valid.
REQ-009 SHALL have port tk_ready, input, 1: consumer accepts the result.
REQ-010 SHALL have port taken, output, 1: evaluated condition; held stable while tk_valid=1 and tk_ready=0.
REQ-011 SHALL have port flags, output, 3: registered {Z,N,V}.
REQ-012 SHALL have port stall, output, 1: hazard wait in progress.

Function
REQ-013 SHALL decode br_cond as follows: 000 EQ=Z; 001 NE=~Z; 010 LT=N^V; 011 GE=~(N^V); 100 VS=V; 101 VC=~V; 110 MI=N; 111 AL=1.
REQ-014 SHALL implement states IDLE, WAIT and HOLD.
REQ-015 SHALL drive br_ready=1 in IDLE, or in HOLD when tk_ready=1; br_ready SHALL be 0 in WAIT.
REQ-016 SHALL handle an accept with no simultaneous flag_we as follows: evaluate against the flag register, register taken, enter HOLD, and assert tk_valid the next cycle (latency 1).
REQ-017 SHALL leave HOLD on tk_valid&tk_ready: to IDLE, or remain in HOLD with a new result when a new request is accepted the same cycle (back-to-back, 1 result/cycle).
REQ-018 SHALL treat an accept in the same cycle as flag_we as a hazard, resolved per REQ-026/REQ-027.
REQ-019 SHALL apply flag_we in every state; a result already held in HOLD SHALL NOT change.
REQ-020 SHALL drive stall=1 only in WAIT.
REQ-021 SHALL NOT issue a request when br_valid=0 or br_ready=0, and SHALL NOT change state in that case except via tk_ready.

Reset
REQ-022 SHALL, when rst_n=0 at a rising edge, set state=IDLE, flags=000, taken=0, tk_valid=0 and stall=0.
REQ-023 SHALL discard any in-flight request or held result on reset, including one in WAIT or HOLD.
REQ-024 SHALL give reset priority over flag_we and br_valid in the same cycle.
REQ-025 SHALL drive br_ready=1 on the first cycle after reset release.

Configuration
REQ-026 SHALL, with macro FLAG_FWD_EN defined, evaluate a hazard accept against the incoming zin/nin/vin (forwarded), with latency 1, no WAIT state used, and stall tied to 0.
REQ-027 SHALL, without FLAG_FWD_EN, on a hazard accept latch br_cond, enter WAIT for one cycle with stall=1, evaluate from the updated flag register, then enter HOLD, with tk_valid asserted 2 cycles after the accept.

Verification
REQ-028 SHALL pass this scenario: write flags Z=1,N=0,V=0; next cycle request cond=000 with tk_ready=1 -> taken=1, tk_valid=1 one cycle later; cond=001 -> taken=0.
REQ-029 SHALL pass this scenario: flags N=1,V=1, request LT(010) -> taken=0; flags N=1,V=0, request LT -> taken=1, GE(011) -> taken=0.
REQ-030 SHALL pass this scenario: request cond=111 with tk_ready held 0 for 3 cycles -> tk_valid=1 and taken=1 stable; br_ready=0; flag_we during the hold leaves taken unchanged.
REQ-031 SHALL pass this scenario: flag_we with Z=1 (old Z=0) in the same cycle as a cond=000 request -> with FLAG_FWD_EN, taken=1 after 1 cycle and stall=0; without it, stall=1 for 1 cycle and then taken=1 with tk_valid 2 cycles after the request.
REQ-032 SHALL pass this scenario: rst_n=0 asserted while in HOLD or WAIT -> next cycle tk_valid=0, flags=000, stall=0 and br_ready=1 after release.
REQ-033 SHALL pass this scenario: back-to-back requests cond=100 and 101 with V=1 and tk_ready=1 -> taken=1 then 0 on consecutive cycles, with no bubble.
